// File: rtl/switch_debounce_sync_pkg.sv
// switch_debounce_sync_pkg: FSM encoding and debounce timing defaults shared by the switch input stage
package switch_debounce_sync_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SETTLE = 1'b1} state_t;
  localparam int STABLE_CYCLES_SYN = 16;
  localparam int STABLE_CYCLES_SIM = 4;
endpackage

// File: rtl/switch_debounce_sync_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs, cleared by async active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sync1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end
endmodule

// File: rtl/switch_debounce_sync.sv
// switch_debounce_sync: synchronizes and debounces board switches into a stable word plus update strobe.
// Define SWITCH_DEBOUNCE_COUNT_EN to add the 8-bit change_count output.
module switch_debounce_sync
  import switch_debounce_sync_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = STABLE_CYCLES_SYN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] data,
  output logic             update,
  output logic             settling
`ifdef SWITCH_DEBOUNCE_COUNT_EN
  ,
  output logic [7:0]       change_count
`endif
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] sync2, candidate, candidate_nx, data_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic update_nx;
  sync_2ff #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw_in),
    .q    (sync2)
  );
  always_comb begin
    state_nx     = state;
    candidate_nx = candidate;
    data_nx      = data;
    count_nx     = count;
    update_nx    = 1'b0;
    if (state == ST_IDLE) begin
      count_nx = '0;
      if (sync2 != data) begin
        state_nx     = ST_SETTLE;
        candidate_nx = sync2;
        count_nx     = CNT_W'(1);
      end
    end else if (sync2 == candidate) begin
      if (count == LAST) begin
        data_nx   = candidate;
        update_nx = 1'b1;
        count_nx  = '0;
        state_nx  = ST_IDLE;
      end else begin
        count_nx = count + 1'b1;
      end
    end else if (sync2 == data) begin
      state_nx = ST_IDLE;
      count_nx = '0;
    end else begin
      // a different value restarts qualification instead of returning to idle
      candidate_nx = sync2;
      count_nx     = CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      candidate <= '0;
      data      <= '0;
      count     <= '0;
      update    <= 1'b0;
    end else begin
      state     <= state_nx;
      candidate <= candidate_nx;
      data      <= data_nx;
      count     <= count_nx;
      update    <= update_nx;
    end
  end
  assign settling = (state == ST_SETTLE);
`ifdef SWITCH_DEBOUNCE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) change_count <= '0;
    else if (update_nx) change_count <= change_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb_switch_debounce_sync: randomized and directed checks against a sliding-window debounce model
module tb_switch_debounce_sync;
  import switch_debounce_sync_pkg::*;
  localparam int N = STABLE_CYCLES_SIM;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] sw_in = 4'h0;
  logic [3:0] data;
  logic update, settling;
`ifdef SWITCH_DEBOUNCE_COUNT_EN
  logic [7:0] change_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [3:0] raw_q[$];
  logic [3:0] win_q[$];
  logic [3:0] m_data;
  logic m_update, m_settling;
  logic [7:0] m_cc;
  always #5 clk = ~clk;
  switch_debounce_sync #(.WIDTH(4), .STABLE_CYCLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_in   (sw_in),
    .data    (data),
    .update  (update),
    .settling(settling)
`ifdef SWITCH_DEBOUNCE_COUNT_EN
    ,
    .change_count(change_count)
`endif
  );
  task automatic model_clear();
    raw_q.delete();
    win_q.delete();
    m_data = 4'h0;
    m_update = 1'b0;
    m_settling = 1'b0;
    m_cc = 8'h0;
  endtask
  // Model: a word is accepted once the last N values seen past the two-cycle
  // synchronizer delay are identical and differ from the current output.
  task automatic tick();
    logic [3:0] s;
    bit same;
    @(posedge clk);
    if (reset) begin
      raw_q.push_back(sw_in);
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      s = (raw_q.size() == 3) ? raw_q[0] : 4'h0;
      win_q.push_back(s);
      if (win_q.size() > N) void'(win_q.pop_front());
      same = (win_q.size() == N);
      foreach (win_q[i]) if (win_q[i] != s) same = 0;
      m_update = same && (s != m_data);
      if (m_update) begin
        m_data = s;
        m_cc = m_cc + 8'd1;
      end
      m_settling = (s != m_data);
    end
    @(negedge clk);
  endtask
  task automatic hold(input logic [3:0] v, input int n);
    sw_in = v;
    repeat (n) tick();
  endtask
  task automatic test_reset();
    model_clear();
    sw_in = 4'hF;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({data, update, settling} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold data=%h update=%b settling=%b expected 0 0 0", data, update, settling);
      end
    end
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if ({data, update, settling} !== {m_data, m_update, m_settling}) begin
        errors++;
        $display("FAIL reset_release e=%0d got %h %b %b expected %h %b %b", e, data, update, settling, m_data, m_update, m_settling);
      end
      if (e == 5) begin
        checks++;
        if (update !== 1'b1 || data !== 4'hF) begin
          errors++;
          $display("FAIL reset_first_update update=%b data=%h expected 1 f", update, data);
        end
      end
    end
  endtask
  task automatic test_clean_step();
    hold(4'h0, 8);
    sw_in = 4'h3;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if ({data, update, settling} !== {m_data, m_update, m_settling}) begin
        errors++;
        $display("FAIL clean_step e=%0d got %h %b %b expected %h %b %b", e, data, update, settling, m_data, m_update, m_settling);
      end
      if (e == 2) begin
        checks++;
        if (settling !== 1'b1) begin
          errors++;
          $display("FAIL clean_settling settling=%b expected 1", settling);
        end
      end
      if (e == 5) begin
        checks++;
        if (update !== 1'b1 || data !== 4'h3) begin
          errors++;
          $display("FAIL clean_update update=%b data=%h expected 1 3", update, data);
        end
      end
      if (e == 6) begin
        checks++;
        if (update !== 1'b0) begin
          errors++;
          $display("FAIL clean_pulse update=%b expected 0", update);
        end
      end
    end
  endtask
  task automatic test_bounce();
    bit saw_settling = 0;
    bit saw_update = 0;
    hold(4'h0, 8);
    sw_in = 4'h7;
    for (int e = 0; e < 10; e++) begin
      if (e == 2) sw_in = 4'h0;
      tick();
      saw_settling |= settling;
      saw_update |= update;
      checks++;
      if ({data, update, settling} !== {m_data, m_update, m_settling}) begin
        errors++;
        $display("FAIL bounce e=%0d got %h %b %b expected %h %b %b", e, data, update, settling, m_data, m_update, m_settling);
      end
    end
    checks++;
    if (!saw_settling || saw_update || data !== 4'h0 || settling !== 1'b0) begin
      errors++;
      $display("FAIL bounce_summary saw_settling=%b saw_update=%b data=%h settling=%b expected 1 0 0 0", saw_settling, saw_update, data, settling);
    end
  endtask
  task automatic test_glitch();
    int updates = 0;
    bit seen1 = 0;
    hold(4'h0, 8);
    sw_in = 4'h1;
    for (int e = 0; e < 12; e++) begin
      if (e == 2) sw_in = 4'h5;
      tick();
      updates += int'(update);
      seen1 |= (data == 4'h1);
      checks++;
      if ({data, update, settling} !== {m_data, m_update, m_settling}) begin
        errors++;
        $display("FAIL glitch e=%0d got %h %b %b expected %h %b %b", e, data, update, settling, m_data, m_update, m_settling);
      end
      if (e == 7) begin
        checks++;
        if (update !== 1'b1 || data !== 4'h5) begin
          errors++;
          $display("FAIL glitch_update update=%b data=%h expected 1 5", update, data);
        end
      end
    end
    checks++;
    if (updates != 1 || seen1) begin
      errors++;
      $display("FAIL glitch_summary updates=%0d seen1=%b expected 1 0", updates, seen1);
    end
  endtask
  task automatic test_reset_mid_settle();
    int first = -1;
    hold(4'h3, 8);
    sw_in = 4'h6;
    repeat (4) tick();
    checks++;
    if (settling !== 1'b1 || data !== 4'h3) begin
      errors++;
      $display("FAIL mid_pre settling=%b data=%h expected 1 3", settling, data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({data, update, settling} !== 6'b0) begin
      errors++;
      $display("FAIL mid_async data=%h update=%b settling=%b expected 0 0 0", data, update, settling);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (update === 1'b1 && first < 0) first = e;
      checks++;
      if ({data, update, settling} !== {m_data, m_update, m_settling}) begin
        errors++;
        $display("FAIL mid_requal e=%0d got %h %b %b expected %h %b %b", e, data, update, settling, m_data, m_update, m_settling);
      end
    end
    checks++;
    if (first != 5 || data !== 4'h6) begin
      errors++;
      $display("FAIL mid_latency first_update=%0d data=%h expected 5 6", first, data);
    end
  endtask
  task automatic test_random();
    logic [3:0] v;
    logic prev_update = 1'b0;
    logic [3:0] prev_data = data;
    for (int k = 0; k < 120; k++) begin
      v = ($urandom_range(0, 3) == 0) ? 4'($urandom) : {2'b00, 2'($urandom)};
      sw_in = v;
      for (int c = $urandom_range(1, 7); c > 0; c--) begin
        tick();
        checks++;
        if ({data, update, settling} !== {m_data, m_update, m_settling} ||
            (update && prev_update) || (data !== prev_data && !update)) begin
          errors++;
          $display("FAIL random k=%0d got %h %b %b expected %h %b %b", k, data, update, settling, m_data, m_update, m_settling);
        end
        prev_update = update;
        prev_data = data;
      end
    end
  endtask
`ifdef SWITCH_DEBOUNCE_COUNT_EN
  task automatic test_change_count();
    reset = 1'b0;
    sw_in = 4'h0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 257; k++) begin
      hold((k % 2 == 0) ? 4'hA : 4'h0, 7);
      checks++;
      if (change_count !== m_cc || data !== m_data) begin
        errors++;
        $display("FAIL change_count k=%0d got %0d data=%h expected %0d %h", k, change_count, data, m_cc, m_data);
      end
    end
    checks++;
    if (change_count !== 8'd1) begin
      errors++;
      $display("FAIL change_count_wrap got %0d expected 1", change_count);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_reset_mid_settle();
    test_random();
`ifdef SWITCH_DEBOUNCE_COUNT_EN
    test_change_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
